inst_fetch_queue: RTL and testbench

Parametrised prefetching instruction-fetch stage. It drives a synchronous-read instruction memory and buffers returned words with their PCs in a QDEPTH-entry queue. It presents one (pc, inst) pair per cycle to decode under a valid/hold handshake. Jumps flush the queue and any in-flight read.

---
 rtl/inst_fetch_queue.sv | 100 ++++++++++
 tb/tb_inst_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Prefetching instruction-fetch stage: drives a synchronous-read instruction memory and
// queues returned words with their PCs, handing one (pc, inst) pair per cycle to decode.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 10,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              nop,
    input  logic              jmp_vld,
    input  logic [31:0]       jmp_addr,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              IF_vld,
    output logic [31:0]       IF_pc,
    output logic [31:0]       IF_inst
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic              started;
    logic [31:0]       fetch_pc;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              inflight;
    logic [31:0]       inflight_pc;
    logic [31:0]       q_pc   [QDEPTH];
    logic [31:0]       q_inst [QDEPTH];

    logic [31:0]       jmp_tgt;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       occ_next;

    assign jmp_tgt = jmp_addr & ~32'h3;

    assign IF_vld  = (count != '0);
    assign IF_pc   = IF_vld ? q_pc[rd_ptr] : 32'h0;
    assign IF_inst = (nop || !IF_vld) ? NOP_INST : q_inst[rd_ptr];

    assign pop  = IF_vld & ~hold & ~jmp_vld;
    assign push = inflight & ~jmp_vld;

    // Occupancy after this edge if nothing new is issued; issuing needs a free slot for its word.
    assign occ_next = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue    = started & (jmp_vld | (occ_next < (CW+1)'(QDEPTH)));

    assign mem_en   = issue;
    assign mem_addr = !started ? '0 :
                      jmp_vld  ? jmp_tgt[MEM_AW+1:2] : fetch_pc[MEM_AW+1:2];

    // The first edge after reset release only arms the fetcher, so the first read lands in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            started <= 1'b1;
            if (started) begin
                if (jmp_vld) begin
                    rd_ptr   <= '0;
                    wr_ptr   <= '0;
                    count    <= '0;
                    inflight <= 1'b1;
                    fetch_pc <= jmp_tgt + 32'd4;
                end else begin
                    rd_ptr   <= rd_ptr + PW'(pop);
                    wr_ptr   <= wr_ptr + PW'(push);
                    count    <= count + CW'(push) - CW'(pop);
                    inflight <= issue;
                    if (issue) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= jmp_vld ? jmp_tgt : fetch_pc;
        end
        if (push) begin
            q_pc[wr_ptr]   <= inflight_pc;
            q_inst[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed literal scenarios plus randomized traffic, all checked
// against a queue-based behavioural model of the fetch stage.
module tb_inst_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          MEM_AW   = 10;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic              hold;
    logic              nop;
    logic              jmp_vld;
    logic [31:0]       jmp_addr;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              IF_vld;
    logic [31:0]       IF_pc;
    logic [31:0]       IF_inst;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_queue #(
        .RESET_PC(RESET_PC),
        .MEM_AW  (MEM_AW),
        .QDEPTH  (QDEPTH),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .nop      (nop),
        .jmp_vld  (jmp_vld),
        .jmp_addr (jmp_addr),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .IF_vld   (IF_vld),
        .IF_pc    (IF_pc),
        .IF_inst  (IF_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word[i] = 0x1000 + i, synchronous read.
    function automatic logic [31:0] mem_word(input logic [MEM_AW-1:0] a);
        return 32'h1000 + {{(32-MEM_AW){1'b0}}, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a list of PCs waiting for decode, one outstanding read, the next fetch PC.
    logic        m_started;
    logic [31:0] m_fetch;
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_q [$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return mem_word(pc[MEM_AW+1:2]);
    endfunction

    initial begin
        m_started = 1'b0; m_fetch = RESET_PC; m_infl = 1'b0; m_infl_pc = '0; m_q.delete();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_started = 1'b0; m_fetch = RESET_PC; m_infl = 1'b0; m_q.delete();
            end else if (!m_started) begin
                m_started = 1'b1;
            end else if (jmp_vld) begin
                m_q.delete();
                m_infl    = 1'b1;
                m_infl_pc = {jmp_addr[31:2], 2'b00};
                m_fetch   = m_infl_pc + 32'd4;
            end else begin
                int occ;
                bit vld, pop;
                vld = (m_q.size() != 0);
                pop = vld && !hold;
                occ = m_q.size() + int'(m_infl) - int'(pop);
                if (pop) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_infl_pc);
                if (occ < QDEPTH) begin
                    m_infl = 1'b1; m_infl_pc = m_fetch; m_fetch = m_fetch + 32'd4;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit          e_vld, e_pop, e_en;
                logic [31:0] e_pc, e_inst, e_addr;
                int          occ;
                e_vld  = (m_q.size() != 0);
                e_pc   = e_vld ? m_q[0] : 32'h0;
                e_inst = (nop || !e_vld) ? NOP_INST : inst_of(e_pc);
                e_pop  = e_vld && !hold && !jmp_vld;
                occ    = m_q.size() + int'(m_infl) - int'(e_pop);
                e_en   = m_started && (jmp_vld || occ < QDEPTH);
                e_addr = !m_started ? 32'h0 :
                         jmp_vld ? {22'b0, jmp_addr[MEM_AW+1:2]} : {22'b0, m_fetch[MEM_AW+1:2]};
                chk("model IF_vld",   {31'b0, IF_vld}, {31'b0, e_vld});
                chk("model IF_pc",    IF_pc,   e_pc);
                chk("model IF_inst",  IF_inst, e_inst);
                chk("model mem_en",   {31'b0, mem_en}, {31'b0, e_en});
                chk("model mem_addr", {22'b0, mem_addr}, e_addr);
            end
        end
    end

    task automatic drive(input bit h, input bit n, input bit j, input logic [31:0] a);
        @(posedge clk);
        #1;
        hold = h; nop = n; jmp_vld = j; jmp_addr = a;
    endtask

    task automatic expect_head(input string nm, input bit v, input logic [31:0] pc, input logic [31:0] inst);
        chk({nm, " vld"},  {31'b0, IF_vld}, {31'b0, v});
        chk({nm, " pc"},   IF_pc,   pc);
        chk({nm, " inst"}, IF_inst, inst);
    endtask

    task automatic reset_outputs(input string nm);
        expect_head(nm, 1'b0, 32'h0, NOP_INST);
        chk({nm, " mem_en"},   {31'b0, mem_en}, 32'h0);
        chk({nm, " mem_addr"}, {22'b0, mem_addr}, 32'h0);
    endtask

    task automatic restart_from_reset(input string nm);
        @(negedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk({nm, " C0 mem_en"},   {31'b0, mem_en}, 32'h1);
        chk({nm, " C0 mem_addr"}, {22'b0, mem_addr}, 32'h40);
        @(negedge clk);
        chk({nm, " C1 vld"}, {31'b0, IF_vld}, 32'h0);
        @(negedge clk);
        expect_head({nm, " C2"}, 1'b1, 32'h100, 32'h1040);
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; nop = 1'b0; jmp_vld = 1'b0; jmp_addr = 32'h0;
        repeat (3) @(negedge clk);
        reset_outputs("reset");

        // Start-up and back-to-back stream
        restart_from_reset("startup");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            expect_head("stream", 1'b1, 32'h100 + 32'(4 * k), 32'h1040 + 32'(k));
        end

        // Decode stall for 10 cycles
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            expect_head("hold", 1'b1, 32'h110, 32'h1044);
        end
        chk("hold full mem_en", {31'b0, mem_en}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("release mem_en", {31'b0, mem_en}, 32'h1);
        expect_head("release", 1'b1, 32'h110, 32'h1044);

        // Jump together with hold while the queue is at capacity with a read outstanding
        drive(1'b1, 1'b0, 1'b1, 32'h203);
        @(negedge clk);
        chk("jmp mem_addr", {22'b0, mem_addr}, 32'h80);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("jmp bubble vld", {31'b0, IF_vld}, 32'h0);
        @(negedge clk);
        expect_head("jmp tgt", 1'b1, 32'h200, 32'h1080);
        @(negedge clk);
        expect_head("jmp tgt+4", 1'b1, 32'h204, 32'h1081);

        // nop override on a valid head
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        expect_head("nop", 1'b1, 32'h208, NOP_INST);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        expect_head("after nop", 1'b1, 32'h20C, 32'h1083);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap jmp mem_addr", {22'b0, mem_addr}, 32'h3FF);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("wrap mem_en",   {31'b0, mem_en}, 32'h1);
        chk("wrap mem_addr", {22'b0, mem_addr}, 32'h0);
        @(negedge clk);
        expect_head("wrap top", 1'b1, 32'hFFFF_FFFC, 32'h13FF);
        @(negedge clk);
        expect_head("wrap zero", 1'b1, 32'h0, 32'h1000);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 12) == 0, $urandom);
        end

        // Asynchronous reset mid-cycle with a read outstanding
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs("async reset");
        restart_from_reset("restart");
        @(negedge clk);
        expect_head("restart+1", 1'b1, 32'h104, 32'h1041);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
